// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative radix-2 multiply/divide unit with PC/writeback stall control; optional MULDIV_EARLY_OUT_EN.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state, state_nx;
    logic [2*WIDTH-1:0] acc, acc_nx, mcand, prod_fix;
    logic [WIDTH-1:0]   opb, mag_a, mag_b, quo_fix, rem_fix;
    logic [WIDTH:0]     diff;
    logic [CW-1:0]      count;
    logic               is_div, sign_a, sign_b, sa, sb, last, by_zero, take;

    // operand conditioning, one radix-2 step, and sign fix-up of the step result
    always_comb begin
        sa       = ~op[1] & a[WIDTH-1];
        sb       = ~op[1] & b[WIDTH-1];
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
        by_zero  = op[0] & (b == '0);
        take     = (state == IDLE) & start;
        diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
        acc_nx   = is_div ? (diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                         : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                          : (opb[0] ? acc + mcand : acc);
`ifdef MULDIV_EARLY_OUT_EN
        last     = (count == CW'(WIDTH-1)) | (~is_div & (opb[WIDTH-1:1] == '0));
`else
        last     = count == CW'(WIDTH-1);
`endif
        prod_fix = (sign_a ^ sign_b) ? -acc_nx : acc_nx;
        quo_fix  = (sign_a ^ sign_b) ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
        rem_fix  = sign_a ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];
    end

    // next-state and output decode
    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE) ? (start ? (by_zero ? DONE : RUN) : IDLE)
                 : (state == RUN)  ? (last ? DONE : RUN)
                 : IDLE;
        stall    = take | (state == RUN);
        busy     = state == RUN;
        done     = state == DONE;
    end

    // state register
    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // operand capture, iteration registers and result registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            acc       <= '0;
            mcand     <= '0;
            opb       <= '0;
            count     <= '0;
            is_div    <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            div_zero  <= 1'b0;
        end else if (take) begin
            is_div   <= op[0];
            sign_a   <= sa;
            sign_b   <= sb;
            count    <= '0;
            opb      <= mag_b;
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            acc      <= op[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
            div_zero <= by_zero;
            if (by_zero) begin
                result_lo <= '1;
                result_hi <= a;
            end
        end else if (state == RUN) begin
            acc   <= acc_nx;
            count <= count + CW'(1);
            if (!is_div) begin
                mcand <= mcand << 1;
                opb   <= opb >> 1;
            end
            if (last) begin
                result_lo <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                result_hi <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for the iterative multiply/divide sequencer.
module tb_muldiv_sequencer;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         Reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b, result_lo, result_hi;
    logic         stall, busy, done, div_zero;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .Reset(Reset), .start(start), .op(op), .a(a), .b(b),
        .stall(stall), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    function automatic int mul_lat(input logic [1:0] o, input logic [W-1:0] y);
        logic [W-1:0] m;
        int msb;
        m = (!o[1] && y[W-1]) ? -y : y;
        msb = 0;
        for (int i = 0; i < W; i++) if (m[i]) msb = i;
`ifdef MULDIV_EARLY_OUT_EN
        return msb + 2;
`else
        return W + 1;
`endif
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = o[1] ? longint'(x) : longint'($signed(x));
        sy = o[1] ? longint'(y) : longint'($signed(y));
        e.dz = o[0] && (y == '0);
        if (!o[0]) begin
            p = 64'(sx * sy);
            e.lo = p[W-1:0];
            e.hi = p[2*W-1:W];
            e.lat = mul_lat(o, y);
        end else if (e.dz) begin
            e.lo = '1;
            e.hi = x;
            e.lat = 1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            e.lo = q[W-1:0];
            e.hi = r[W-1:0];
            e.lat = W + 1;
        end
        return e;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output exp_t r, output int stalls, output bit tmo);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1 stalls = int'(stall);
        @(negedge clk);
        start = 1'b0;
        r.lat = 1;
        #1;
        while (done !== 1'b1 && r.lat < 100) begin
            stalls += int'(stall);
            @(negedge clk);
            r.lat++;
            #1;
        end
        stalls += int'(stall);
        tmo = done !== 1'b1;
        r.lo = result_lo;
        r.hi = result_hi;
        r.dz = div_zero;
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset stall: got %b want 0", stall); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", done); end
        n_cmp++; if (result_lo !== '0) begin n_bad++; $display("FAIL reset lo: got %h want 0", result_lo); end
        n_cmp++; if (result_hi !== '0) begin n_bad++; $display("FAIL reset hi: got %h want 0", result_hi); end
        n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset div_zero: got %b want 0", div_zero); end
    endtask

    task automatic test_arith();
        logic [1:0]   t_op [18];
        logic [W-1:0] t_a [18];
        logic [W-1:0] t_b [18];
        exp_t e, r;
        int   st;
        bit   tmo;
        t_op[0:11] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
        t_a[0:11]  = '{-32'sd10, 32'd492, -32'sd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                       32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd5, 32'd3};
        t_b[0:11]  = '{32'd123, 32'd10, 32'd2, 32'd2, 32'd3, 32'hFFFF_FFFF,
                       32'd5, 32'h8000_0000, 32'hFFFF_FFFF, -32'sd2, 32'd0, 32'd1};
        for (int i = 12; i < 18; i++) begin
            t_op[i] = 2'($urandom_range(0, 3));
            t_a[i]  = $urandom;
            t_b[i]  = $urandom >> $urandom_range(0, 28);
            if (t_op[i][0] && t_b[i] == '0) t_b[i] = 32'd1;
        end
        for (int i = 0; i < 18; i++) begin
            sb.push_back(model(t_op[i], t_a[i], t_b[i]));
            run_op(t_op[i], t_a[i], t_b[i], r, st, tmo);
            e = sb.pop_front();
            n_cmp++; if (tmo) begin n_bad++; $display("FAIL arith[%0d] timeout: no done within 100 cycles", i); end
            n_cmp++; if (r.lo !== e.lo) begin n_bad++; $display("FAIL arith[%0d] lo: got %h want %h", i, r.lo, e.lo); end
            n_cmp++; if (r.hi !== e.hi) begin n_bad++; $display("FAIL arith[%0d] hi: got %h want %h", i, r.hi, e.hi); end
            n_cmp++; if (r.dz !== e.dz) begin n_bad++; $display("FAIL arith[%0d] div_zero: got %b want %b", i, r.dz, e.dz); end
            n_cmp++; if (r.lat != e.lat) begin n_bad++; $display("FAIL arith[%0d] latency: got %0d want %0d", i, r.lat, e.lat); end
            n_cmp++; if (st != e.lat) begin n_bad++; $display("FAIL arith[%0d] stall cycles: got %0d want %0d", i, st, e.lat); end
        end
    endtask

    task automatic test_div_zero();
        exp_t e, r;
        int   st, n;
        bit   tmo;
        sb.push_back(model(2'b01, 32'd5, 32'd0));
        run_op(2'b01, 32'd5, 32'd0, r, st, tmo);
        e = sb.pop_front();
        n_cmp++; if (r.lat != 1 || tmo) begin n_bad++; $display("FAIL divzero latency: got %0d want 1", r.lat); end
        n_cmp++; if (r.lo !== e.lo || r.hi !== e.hi) begin n_bad++; $display("FAIL divzero result: got %h_%h want %h_%h", r.hi, r.lo, e.hi, e.lo); end
        n_cmp++; if (r.dz !== 1'b1) begin n_bad++; $display("FAIL divzero flag: got %b want 1", r.dz); end
        @(negedge clk); #1;
        n_cmp++; if (div_zero !== 1'b1 || result_lo !== '1) begin n_bad++; $display("FAIL divzero hold: got dz=%b lo=%h want dz=1 lo=ffffffff", div_zero, result_lo); end
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd492; b = 32'd10;
        sb.push_back(model(2'b01, 32'd492, 32'd10));
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (div_zero !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL divzero clear: got dz=%b busy=%b want dz=0 busy=1", div_zero, busy); end
        n = 1;
        while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; #1; end
        e = sb.pop_front();
        n_cmp++; if (done !== 1'b1 || result_lo !== e.lo || result_hi !== e.hi) begin n_bad++; $display("FAIL divzero next op: got done=%b %h_%h want %h_%h", done, result_hi, result_lo, e.hi, e.lo); end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2, e;
        int   d1, d2, seen;
        e1 = model(2'b00, 32'd3, 32'd4);
        e2 = model(2'b00, 32'd6, 32'd7);
        d1 = e1.lat;
        d2 = d1 + 1 + e2.lat;
        seen = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        sb.push_back(e1);
        for (int c = 1; c <= d2 + 3; c++) begin
            @(negedge clk);
            if (c == 2) begin a = 32'd6; b = 32'd7; sb.push_back(e2); end
            #1;
            if (c == d1 + 1) begin
                n_cmp++; if (stall !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b reissue: got stall=%b busy=%b want stall=1 busy=0", stall, busy); end
            end
            if (done === 1'b1) begin
                seen++;
                n_cmp++; if (c != d1 && c != d2) begin n_bad++; $display("FAIL b2b done timing: got done at cycle %0d want %0d or %0d", c, d1, d2); end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_cmp++; if (result_lo !== e.lo || result_hi !== e.hi) begin n_bad++; $display("FAIL b2b result: got %h_%h want %h_%h", result_hi, result_lo, e.hi, e.lo); end
                end
            end
            if (c == d2) start = 1'b0;
        end
        start = 1'b0;
        n_cmp++; if (seen != 2) begin n_bad++; $display("FAIL b2b done count: got %0d want 2", seen); end
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        exp_t e, r;
        int   st, n_done;
        bit   tmo;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'h8000_0001;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst busy before: got %b want 1", busy); end
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL midrst state: got busy=%b stall=%b done=%b want 0 0 0", busy, stall, done); end
        n_cmp++; if (result_lo !== '0 || result_hi !== '0 || div_zero !== 1'b0) begin n_bad++; $display("FAIL midrst results: got %h_%h dz=%b want zeros", result_hi, result_lo, div_zero); end
        n_done = 0;
        repeat (40) begin @(negedge clk); #1; if (done === 1'b1) n_done++; end
        n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL midrst done pulses: got %0d want 0", n_done); end
        sb.push_back(model(2'b00, -32'sd6, -32'sd7));
        run_op(2'b00, -32'sd6, -32'sd7, r, st, tmo);
        e = sb.pop_front();
        n_cmp++; if (tmo || r.lo !== e.lo || r.hi !== e.hi) begin n_bad++; $display("FAIL midrst recovery: got %h_%h want %h_%h", r.hi, r.lo, e.hi, e.lo); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multi-cycle multiply/divide unit and its sequencing controller for the single-cycle MIPS datapath. It accepts a mul/div request from the datapath's decode and stalls the PC and register-file write until the result is ready. On completion it presents the 64-bit result (lo/hi) for one-cycle writeback. It replaces the combinational `*` and `/` in the ALU path.

## Interface
Parameters:
- `WIDTH`, 32: operand width. The count register is `$clog2(WIDTH)+1` bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `op`  in  2  bit0: 0 = multiply, 1 = divide. bit1: 0 = signed, 1 = unsigned.
- `a`  in  WIDTH  multiplicand or dividend (rs).
- `b`  in  WIDTH  multiplier or divisor (rt).
- `stall`  out  1  holds the PC and register writes.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `result_lo`  out  WIDTH  product[WIDTH-1:0] or quotient.
- `result_hi`  out  WIDTH  product[2*WIDTH-1:WIDTH] or remainder.
- `div_zero`  out  1  divisor was zero; valid while `done`, then held.

## Operation
States: IDLE, RUN, DONE.

- **IDLE**
  - If `start`=1: capture `a`, `b`, `op`; set count to 0.
  - Signed mode: store |a|, |b| and the sign flags.
  - Next state is RUN. If divide with `b`==0, next state is DONE instead.
- **RUN**
  - Each cycle performs one radix-2 step.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Count increments each cycle. After the step where count reaches WIDTH-1, next state is DONE.
- **DONE**
  - `done`=1 for exactly one cycle. Result registers hold final values.
  - Next state is IDLE unconditionally.
- **Sign fix-up** (signed mode), applied on entry to DONE:
  - Product is negated if sign_a ^ sign_b.
  - Quotient is negated if sign_a ^ sign_b. Truncation is toward zero.
  - Remainder takes the sign of the dividend.
- **Divide by zero**
  - `result_lo` = all ones, `result_hi` = a (unmodified), `div_zero`=1.
  - No RUN cycles are spent.
- **Results**
  - Multiply returns the full 2·WIDTH product.
  - Signed -2^31 operands are handled through unsigned magnitude, with no overflow flag. -2^31 / -1 gives lo = 0x80000000, hi = 0.
  - Result registers and `div_zero` hold their values until the next capture.
- **Output decode**
  - `stall` = (IDLE & `start`) | RUN. This is combinational from state and `start`.
  - `stall` is low in DONE, so the datapath writes back and advances in that cycle.
- **`start` outside IDLE**: ignored in RUN and DONE; no queueing.
- **Reset**
  - Forces IDLE from any state, including mid-RUN.
  - Zeroes the accumulator, count, `result_lo`, `result_hi` and `div_zero`.
  - An operation in flight is discarded.

## Timing
- Reset values: `stall`=0 (given `start`=0), `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0, `div_zero`=0.
- Start sampled at edge E:
  - RUN occupies the cycles after edges E+1 … E+WIDTH.
  - `done`=1 in the cycle after edge E+WIDTH+1.
  - Latency is WIDTH+1 = 33 cycles; `stall` is high for 33 cycles counting the request cycle.
- Divide by zero: `done` in the cycle after edge E+1, so latency is 1.
- Back-to-back: a new `start` is accepted on the edge leaving DONE→IDLE, i.e. the following cycle. Minimum issue interval is WIDTH+2 cycles.
- Outputs are registered, except `stall`.

## Configuration
- Macro `MULDIV_EARLY_OUT_EN`.
- **Defined**: in a multiply RUN, if the remaining unprocessed multiplier bits are all zero after a step, go directly to DONE.
  - The final product is shifted into position.
  - Latency is (index of the highest set bit of |b|) + 2, minimum 2 cycles (b=0 or 1).
  - Divide latency is unchanged.
- **Undefined**: multiply always takes WIDTH+1 cycles. Results are bit-identical in both builds.

## Test plan
- **Signed multiply**: `op`=00, a=-10, b=123.
  - `result_lo`=0xFFFFFB32 (-1230), `result_hi`=0xFFFFFFFF, `done` 33 cycles after start, `stall` high for 33 cycles.
- **Signed divide**:
  - `op`=01, a=492, b=10 → lo=49, hi=2.
  - a=-7, b=2 → lo=-3 (0xFFFFFFFD), hi=-1.
- **Unsigned**:
  - `op`=10, a=0xFFFFFFFF, b=2 → lo=0xFFFFFFFE, hi=0x00000001.
  - `op`=11, a=0x80000000, b=3 → lo=0x2AAAAAAA, hi=2.
- **Divide by zero**: `op`=01, a=5, b=0 → `done` 1 cycle after start, lo=0xFFFFFFFF, hi=5, `div_zero`=1; `div_zero` clears on the next capture.
- **Hazards**:
  - `start` held high through RUN starts a second operation only after DONE.
  - `Reset` at RUN cycle 10 → next cycle IDLE, `busy`=0, `stall`=0, results 0, and no `done` pulse.
- **`MULDIV_EARLY_OUT_EN` defined**: a=7, b=5 → `done` 4 cycles after start, lo=35. With the macro undefined, the same stimulus gives 33 cycles and the same result.
